// File: rtl/fpmul_log_pkg.sv
// Shared types and constants for the fpmul result logger.
//
// Contents:
//   WORD_W      - width of one streamed record word (32)
//   REC_WORDS   - words per streamed record (4, or 5 with the timestamp word)
//   rec_t       - one aligned record {a, b, c, omu[, ts]}
//   REC_W       - packed width of rec_t, used to size the record FIFO
//   ser_state_t - serializer state encoding
//
// Optional feature macro: FPMUL_LOG_TIMESTAMP_EN adds the issue timestamp
// to each record and the W4 serializer state.
package fpmul_log_pkg;

  localparam int WORD_W = 32;

`ifdef FPMUL_LOG_TIMESTAMP_EN
  localparam int REC_WORDS = 5;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic              omu;
    logic [WORD_W-1:0] ts;
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4,
    ST_W4   = 3'd5
  } ser_state_t;
`else
  localparam int REC_WORDS = 4;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic              omu;
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_W1   = 3'd2,
    ST_W2   = 3'd3,
    ST_W3   = 3'd4
  } ser_state_t;
`endif

  localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/fpmul_result_logger_if.sv
// Record word stream between the fpmul result logger and its consumer.
//
// Signals:
//   out_valid - out_data holds a valid word
//   out_ready - consumer accepts the word when out_valid & out_ready
//   out_data  - current record word
//   out_last  - marks the final word of a record
//
// Modports: master (logger side), slave (consumer side).
interface fpmul_result_logger_if;
  import fpmul_log_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/fpmul_log_fifo.sv
// Synchronous single-clock record FIFO for the fpmul result logger.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointers/count only)
//   push      - write request with push_data
//   pop       - remove the head entry (ignored when empty)
//   pop_data  - head entry, valid whenever empty=0
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - entries currently stored
//
// A push while full is still accepted when the head is popped in the same
// cycle; otherwise a push while full is ignored and the entry is lost.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap naturally.
module fpmul_log_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             pop_fire;
  logic             push_fire;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign pop_fire  = pop & ~empty;
  // Popping frees the slot the incoming entry needs, even when full.
  assign push_fire = push & (~full | pop_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;

endmodule

// File: rtl/fpmul_result_logger.sv
// fpmul result logger: taps the fpmul operands and results, pairs each
// issued operand pair with the result emerging LATENCY cycles later,
// buffers the records and streams them out as 32-bit words.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid      - operand pair on in_a/in_b issued to fpmul this cycle
//   in_a, in_b    - fpmul operands (IEEE-754 single)
//   res_c         - fpmul result c
//   res_omu       - fpmul over_mul_under flag
//   rec_out       - record word stream (master side of the stream interface)
//   fifo_count    - records currently buffered
//   drop_cnt      - records lost to a full FIFO, saturating at 0xFFFF
//   overflow      - sticky, set on the first dropped record
//
// Word order per record: a, b, c, {31'b0, omu}[, issue timestamp].
// Optional feature macro: FPMUL_LOG_TIMESTAMP_EN appends the issue-cycle
// timestamp word; out_last then moves to that word.
module fpmul_result_logger
  import fpmul_log_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_a,
  input  logic [WORD_W-1:0]        in_b,
  input  logic [WORD_W-1:0]        res_c,
  input  logic                     res_omu,
  fpmul_result_logger_if.master    rec_out,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              drop_cnt,
  output logic                     overflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [LATENCY-1:0] vld_p;
  logic [WORD_W-1:0]  a_p [LATENCY];
  logic [WORD_W-1:0]  b_p [LATENCY];

  rec_t       rec_in;
  rec_t       head;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;
  logic       ready;
  ser_state_t state_q;
  ser_state_t state_d;
  logic [WORD_W-1:0] out_word;
  logic       last_word;

`ifdef FPMUL_LOG_TIMESTAMP_EN
  logic [WORD_W-1:0] ts_cnt;
  logic [WORD_W-1:0] ts_p [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end
`endif

  // ---- Alignment pipe: stage 0 captures the issue, stage LATENCY-1 meets the result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    a_p[0] <= in_a;
    b_p[0] <= in_b;
`ifdef FPMUL_LOG_TIMESTAMP_EN
    ts_p[0] <= ts_cnt;
`endif
    for (int i = 1; i < LATENCY; i++) begin
      a_p[i] <= a_p[i-1];
      b_p[i] <= b_p[i-1];
`ifdef FPMUL_LOG_TIMESTAMP_EN
      ts_p[i] <= ts_p[i-1];
`endif
    end
  end

  // ---- Record assembly and push/drop decision
  always_comb begin
    rec_in     = '0;
    rec_in.a   = a_p[LATENCY-1];
    rec_in.b   = b_p[LATENCY-1];
    rec_in.c   = res_c;
    rec_in.omu = res_omu;
`ifdef FPMUL_LOG_TIMESTAMP_EN
    rec_in.ts  = ts_p[LATENCY-1];
`endif
  end

  assign push = vld_p[LATENCY-1];
  // pop is only raised in the final word state, where the FIFO is non-empty.
  assign drop = push & fifo_full & ~pop;

  fpmul_log_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rec_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      drop_cnt <= sat_inc16(drop_cnt);
      overflow <= 1'b1;
    end
  end

  // ---- Serializer: one word per accepted handshake, head popped on the last word
  assign ready = rec_out.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    out_word  = '0;
    last_word = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_W0;
      end
      ST_W0: begin
        out_word = head.a;
        if (ready) state_d = ST_W1;
      end
      ST_W1: begin
        out_word = head.b;
        if (ready) state_d = ST_W2;
      end
      ST_W2: begin
        out_word = head.c;
        if (ready) state_d = ST_W3;
      end
      ST_W3: begin
        out_word = {{(WORD_W-1){1'b0}}, head.omu};
`ifdef FPMUL_LOG_TIMESTAMP_EN
        if (ready) state_d = ST_W4;
      end
      ST_W4: begin
        out_word = head.ts;
`endif
        last_word = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // The head is still counted here, so >1 means another record follows.
    if (last_word && ready) begin
      pop     = 1'b1;
      state_d = (fifo_count > CNT_W'(1)) ? ST_W0 : ST_IDLE;
    end
  end

  assign rec_out.out_valid = (state_q != ST_IDLE);
  assign rec_out.out_data  = out_word;
  assign rec_out.out_last  = last_word;

endmodule

// File: tb/tb_fpmul_result_logger.sv
module tb_fpmul_result_logger;

  logic        clk = 1'b0;
  logic        rst;

  // DUT 1: LATENCY=1, DEPTH=4
  logic        in_valid;
  logic [31:0] in_a, in_b, res_c;
  logic        res_omu;
  logic [2:0]  fifo_count;
  logic [15:0] drop_cnt;
  logic        overflow;

  // DUT 3: LATENCY=3, DEPTH=16
  logic        in3_valid;
  logic [31:0] in3_a, in3_b, res3_c;
  logic        res3_omu;
  logic [4:0]  fifo3_count;
  logic [15:0] drop3_cnt;
  logic        overflow3;

  int n_cmp = 0;
  int n_err = 0;

  fpmul_result_logger_if s1 ();
  fpmul_result_logger_if s3 ();

  fpmul_result_logger #(.LATENCY(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .res_c(res_c), .res_omu(res_omu), .rec_out(s1),
    .fifo_count(fifo_count), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  fpmul_result_logger #(.LATENCY(3), .DEPTH(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in3_valid), .in_a(in3_a), .in_b(in3_b),
    .res_c(res3_c), .res_omu(res3_omu), .rec_out(s3),
    .fifo_count(fifo3_count), .drop_cnt(drop3_cnt), .overflow(overflow3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Check the current word of DUT 1, then advance one cycle.
  task automatic exp1(input string tag, input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, {31'b0, s1.out_valid}, 32'd1);
    chk({tag, ".data"},  s1.out_data, d);
    chk({tag, ".last"},  {31'b0, s1.out_last}, {31'b0, l});
    tick();
  endtask

  task automatic exp3(input string tag, input logic [31:0] d, input logic l);
    chk({tag, ".valid"}, {31'b0, s3.out_valid}, 32'd1);
    chk({tag, ".data"},  s3.out_data, d);
    chk({tag, ".last"},  {31'b0, s3.out_last}, {31'b0, l});
    tick();
  endtask

  // LATENCY=1 issue: operands this cycle, result next cycle; returns two cycles later.
  task automatic issue1(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic omu);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; res_c = c; res_omu = omu;
    tick();
    res_c = 32'h0; res_omu = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; res_c = 32'h0; res_omu = 1'b0;
    in3_valid = 1'b0; in3_a = 32'h0; in3_b = 32'h0; res3_c = 32'h0; res3_omu = 1'b0;
    s1.out_ready = 1'b0;
    s3.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst.valid", {31'b0, s1.out_valid}, 32'd0);
    chk("rst.data",  s1.out_data, 32'h0);
    chk("rst.last",  {31'b0, s1.out_last}, 32'd0);
    chk("rst.count", {29'b0, fifo_count}, 32'd0);
    chk("rst.drop",  {16'b0, drop_cnt}, 32'd0);
    chk("rst.ovf",   {31'b0, overflow}, 32'd0);
    chk("rst.valid3", {31'b0, s3.out_valid}, 32'd0);
    rst = 1'b0;
    s1.out_ready = 1'b1;

    // Basic record: 3.0 * 2.0 = 6.0
    issue1(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0);
    chk("t1.count", {29'b0, fifo_count}, 32'd1);
    chk("t1.idle",  {31'b0, s1.out_valid}, 32'd0);
    tick();
    exp1("t1.w0", 32'h40400000, 1'b0);
    exp1("t1.w1", 32'h40000000, 1'b0);
    exp1("t1.w2", 32'h40C00000, 1'b0);
    exp1("t1.w3", 32'h00000000, 1'b1);
    chk("t1.done.valid", {31'b0, s1.out_valid}, 32'd0);
    chk("t1.done.count", {29'b0, fifo_count}, 32'd0);

    // Overflowing multiply: omu flag lands in W3
    issue1(32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
    tick();
    exp1("t2.w0", 32'h7F000000, 1'b0);
    exp1("t2.w1", 32'h7F000000, 1'b0);
    exp1("t2.w2", 32'h7F800000, 1'b0);
    exp1("t2.w3", 32'h00000001, 1'b1);
    chk("t2.drop", {16'b0, drop_cnt}, 32'd0);

    // Full FIFO: six back-to-back issues with the consumer stalled
    s1.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = 32'h3F800000 + 32'(i);
      in_b = 32'h40000000 + 32'(i);
      res_c   = (i > 0) ? 32'h41000000 + 32'(i - 1) : 32'h0;
      res_omu = (i > 0) ? 1'((i - 1) & 1) : 1'b0;
      tick();
    end
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
    res_c = 32'h41000005; res_omu = 1'b1;
    tick();
    res_c = 32'h0; res_omu = 1'b0;
    chk("t3.count", {29'b0, fifo_count}, 32'd4);
    chk("t3.drop",  {16'b0, drop_cnt}, 32'd2);
    chk("t3.ovf",   {31'b0, overflow}, 32'd1);
    chk("t3.stall.data", s1.out_data, 32'h3F800000);
    s1.out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      exp1($sformatf("t3.r%0d.w0", r), 32'h3F800000 + 32'(r), 1'b0);
      exp1($sformatf("t3.r%0d.w1", r), 32'h40000000 + 32'(r), 1'b0);
      exp1($sformatf("t3.r%0d.w2", r), 32'h41000000 + 32'(r), 1'b0);
      exp1($sformatf("t3.r%0d.w3", r), 32'(r & 1), 1'b1);
    end
    chk("t3.drain.count", {29'b0, fifo_count}, 32'd0);
    chk("t3.drain.valid", {31'b0, s1.out_valid}, 32'd0);

    // Backpressure in W1
    issue1(32'h40400000, 32'h40000000, 32'h40C00000, 1'b0);
    tick();
    exp1("t4.w0", 32'h40400000, 1'b0);
    s1.out_ready = 1'b0;
    chk("t4.hold0", s1.out_data, 32'h40000000);
    tick();
    chk("t4.hold1", s1.out_data, 32'h40000000);
    chk("t4.hold1.last", {31'b0, s1.out_last}, 32'd0);
    tick();
    chk("t4.hold2", s1.out_data, 32'h40000000);
    s1.out_ready = 1'b1;
    exp1("t4.w1", 32'h40000000, 1'b0);
    exp1("t4.w2", 32'h40C00000, 1'b0);
    exp1("t4.w3", 32'h00000000, 1'b1);
    chk("t4.done.valid", {31'b0, s1.out_valid}, 32'd0);

    // LATENCY=3 with a bubble between two issues
    in3_valid = 1'b1; in3_a = 32'h3F800000; in3_b = 32'h40400000;
    tick();
    in3_valid = 1'b0; in3_a = 32'h0; in3_b = 32'h0;
    tick();
    in3_valid = 1'b1; in3_a = 32'h40800000; in3_b = 32'h40A00000;
    tick();
    in3_valid = 1'b0; in3_a = 32'h0; in3_b = 32'h0;
    res3_c = 32'h40400000; res3_omu = 1'b1;
    tick();
    res3_c = 32'hDEADBEEF; res3_omu = 1'b1;
    tick();
    res3_c = 32'h41A00000; res3_omu = 1'b0;
    tick();
    res3_c = 32'h0; res3_omu = 1'b0;
    tick();
    chk("t5.count", {27'b0, fifo3_count}, 32'd2);
    chk("t5.drop",  {16'b0, drop3_cnt}, 32'd0);
    s3.out_ready = 1'b1;
    exp3("t5.r0.w0", 32'h3F800000, 1'b0);
    exp3("t5.r0.w1", 32'h40400000, 1'b0);
    exp3("t5.r0.w2", 32'h40400000, 1'b0);
    exp3("t5.r0.w3", 32'h00000001, 1'b1);
    exp3("t5.r1.w0", 32'h40800000, 1'b0);
    exp3("t5.r1.w1", 32'h40A00000, 1'b0);
    exp3("t5.r1.w2", 32'h41A00000, 1'b0);
    exp3("t5.r1.w3", 32'h00000000, 1'b1);
    chk("t5.done.count", {27'b0, fifo3_count}, 32'd0);
    chk("t5.done.valid", {31'b0, s3.out_valid}, 32'd0);

    // Reset mid-record with two records buffered
    s1.out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40800000;
    tick();
    in_a = 32'h40A00000; in_b = 32'h3F000000; res_c = 32'h40C00000; res_omu = 1'b0;
    tick();
    in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0; res_c = 32'h40200000;
    tick();
    res_c = 32'h0;
    chk("t6.count2", {29'b0, fifo_count}, 32'd2);
    chk("t6.drop.pre", {16'b0, drop_cnt}, 32'd2);
    s1.out_ready = 1'b1;
    exp1("t6.w0", 32'h3FC00000, 1'b0);
    exp1("t6.w1", 32'h40800000, 1'b0);
    chk("t6.w2", s1.out_data, 32'h40C00000);
    rst = 1'b1;
    tick();
    chk("t6.rst.valid", {31'b0, s1.out_valid}, 32'd0);
    chk("t6.rst.data",  s1.out_data, 32'h0);
    chk("t6.rst.last",  {31'b0, s1.out_last}, 32'd0);
    chk("t6.rst.count", {29'b0, fifo_count}, 32'd0);
    chk("t6.rst.drop",  {16'b0, drop_cnt}, 32'd0);
    chk("t6.rst.ovf",   {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    issue1(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    tick();
    exp1("t6.new.w0", 32'h40000000, 1'b0);
    exp1("t6.new.w1", 32'h40400000, 1'b0);
    exp1("t6.new.w2", 32'h40C00000, 1'b0);
    exp1("t6.new.w3", 32'h00000000, 1'b1);
    chk("t6.new.done", {31'b0, s1.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpmul_result_logger.md
Name: fpmul_result_logger

Overview:
- Capture end of the fpmul vector flow: records each issued operand pair together with the fpmul result that emerges LATENCY cycles later.
- Buffers the aligned records in an on-chip FIFO.
- Streams each record out as 32-bit words over a valid/ready interface for readout or dump.
- Sits beside fpmul, tapping its a/b inputs and c/over_mul_under outputs.

Parameters:
- LATENCY, 1, fpmul pipeline depth in cycles from operand issue to valid c/over_mul_under; legal range 1..8.
- DEPTH, 16, record FIFO depth; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on in_a/in_b issued to fpmul this cycle.
- in_a  input  32  fpmul operand a (IEEE-754 single).
- in_b  input  32  fpmul operand b.
- res_c  input  32  fpmul result c.
- res_omu  input  1  fpmul over_mul_under flag.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts word when out_valid & out_ready.
- out_data  output  32  current record word.
- out_last  output  1  marks final word of a record.
- fifo_count  output  $clog2(DEPTH)+1  records currently buffered.
- drop_cnt  output  16  records lost to full FIFO; saturates at 0xFFFF.
- overflow  output  1  sticky, set on first drop.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Clears the alignment pipe, FIFO pointers, serializer FSM and counters.
  - Outputs after reset: out_valid=0, out_data=0, out_last=0, fifo_count=0, drop_cnt=0, overflow=0.
  - Reset during a partially sent record discards that record; no resume.
- Alignment pipe:
  - LATENCY-stage shift register of {in_valid, in_a, in_b}.
  - Stage LATENCY output pairs with res_c/res_omu sampled in the same cycle to form record {a, b, c, omu}.
  - Gaps in in_valid propagate as bubbles; no record is pushed for a bubble.
- Push:
  - Occurs when the aligned valid is 1.
  - Accepted if fifo_count < DEPTH, or if the head record is popped in the same cycle (last word handshake).
  - Otherwise the record is dropped, drop_cnt increments (saturating) and overflow is set.
  - Records are never partially stored.
- Serializer FSM:
  - States: IDLE -> W0 -> W1 -> W2 -> W3 -> IDLE (W4 when optional feature is enabled).
  - IDLE -> W0 when the FIFO is non-empty; out_valid=1 in W0..last state.
  - Word order: W0=a, W1=b, W2=c, W3={31'b0, omu}.
  - out_last=1 only in the final state.
  - Advance on out_valid & out_ready only. While out_ready=0, out_data and out_last hold stable.
  - Record pop (fifo_count decrement) on acceptance of the final word.
  - From the final state, go directly to W0 if another record is buffered: back-to-back records with no idle cycle.
- fifo_count reflects the registered state; simultaneous push+pop leaves it unchanged.
- Steady-state readout costs 4 cycles per record (5 with the optional feature). Sustained issue of one operand pair per cycle overflows by design; drops are counted, never silent.

Optional Feature:
- Macro: FPMUL_LOG_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter (reset to 0, wraps at 2^32) is sampled at operand issue and carried through the alignment pipe.
  - The record gains word W4 = issue timestamp; out_last moves to W4.
- When undefined: no counter, 4-word records, W3 carries out_last.

Decomposition:
- Package fpmul_log_pkg holds:
  - WORD_W=32.
  - The record struct typedef {a, b, c, omu[, ts]}.
  - The serializer state enum.
  - REC_WORDS constant (4 or 5 under the macro).
- Sub-module fpmul_log_fifo: synchronous single-clock FIFO, parameterised width/depth, with full/empty/count and the same-cycle push-on-pop rule.
- Top level contains the alignment pipe, drop logic and serializer.

Test Plan:
- LATENCY=1: issue a=0x40400000, b=0x40000000; fpmul returns c=0x40C00000, omu=0 -> words 0x40400000, 0x40000000, 0x40C00000, 0x00000000, out_last on the 4th.
- Overflow case: a=b=0x7F000000 with res_omu=1 -> W3=0x00000001; drop_cnt stays 0.
- DEPTH=4, out_ready=0, six consecutive issues -> fifo_count=4, drop_cnt=2, overflow=1; then out_ready=1 yields the first four records in issue order, 16 words, with no idle cycle between records.
- Backpressure: toggle out_ready 1,0,0,1 during W1 -> out_data holds 0x40000000 for the stalled cycles; no word is duplicated or skipped.
- LATENCY=3: issue pairs on cycles 0, 2 (bubble at 1) with distinct results driven at cycles 3, 5 -> exactly 2 records, each paired with its own result.
- Assert rst while in W2 with 2 records buffered -> next cycle out_valid=0, fifo_count=0, drop_cnt=0; a fresh issue after reset streams normally starting at W0.
